// File: rtl/cjb_nbit_demux1to4_buf_v.sv
// cjb_nbit_demux1to4_buf_v
//
// Buffered n-bit 1-to-4 demultiplexer. Each accepted input word is steered
// by s into one of four independent 2-entry FIFOs; every channel has its own
// valid/ready handshake toward its consumer, so a stalled consumer never
// blocks or reorders traffic on the other channels.
//
// Ports:
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   d [n-1:0]      input data word
//   s [1:0]        channel select for d
//   in_valid       d/s valid
//   in_ready       channel s has a free slot (registered occupancy only)
//   f0..f3 [n-1:0] head word of each channel FIFO
//   out_valid[3:0] bit k: fk valid
//   out_ready[3:0] bit k: consumer k takes fk
//
// Build option:
//   CJB_DEMUX_ZERO_IDLE_EN  defined   -> fk forced to zero while out_valid[k]=0
//                           undefined -> fk shows head storage (stale after drain)
//
// Per-channel occupancy states:
//   state | meaning
//   EMPTY | no word buffered, out_valid low
//   ONE   | head word in e0
//   FULL  | head in e0, second word in e1, in_ready low for this channel

module cjb_nbit_demux1to4_buf_v #(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [n-1:0] d,
  input  logic [1:0]   s,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] f3,
  output logic [n-1:0] f2,
  output logic [n-1:0] f1,
  output logic [n-1:0] f0,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t         occ_q [4];
  occ_t         occ_d [4];
  logic [n-1:0] e0_q  [4];
  logic [n-1:0] e0_d  [4];
  logic [n-1:0] e1_q  [4];
  logic [n-1:0] e1_d  [4];
  logic [n-1:0] head  [4];
  logic [3:0]   push;
  logic [3:0]   pop;

  // Ready is a pure function of the select and registered occupancy, so no
  // combinational path exists from out_ready back to in_ready.
  assign in_ready = (occ_q[s] != FULL);

  always_comb begin
    out_valid = '0;
    push      = '0;
    pop       = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (occ_q[k] != EMPTY);
      push[k]      = in_valid && in_ready && (s == 2'(k));
      pop[k]       = out_valid[k] && out_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      occ_d[k] = occ_q[k];
      e0_d[k]  = e0_q[k];
      e1_d[k]  = e1_q[k];
      case (occ_q[k])
        EMPTY: begin
          if (push[k]) begin
            occ_d[k] = ONE;
            e0_d[k]  = d;
          end
        end
        ONE: begin
          // Push with same-edge pop: the new word replaces the departing head.
          if (push[k] && pop[k]) begin
            e0_d[k] = d;
          end else if (push[k]) begin
            occ_d[k] = FULL;
            e1_d[k]  = d;
          end else if (pop[k]) begin
            occ_d[k] = EMPTY;
          end
        end
        FULL: begin
          if (pop[k]) begin
            occ_d[k] = ONE;
            e0_d[k]  = e1_q[k];
          end
        end
        default: begin
          occ_d[k] = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        occ_q[k] <= EMPTY;
        e0_q[k]  <= '0;
        e1_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        occ_q[k] <= occ_d[k];
        e0_q[k]  <= e0_d[k];
        e1_q[k]  <= e1_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
`ifdef CJB_DEMUX_ZERO_IDLE_EN
      head[k] = out_valid[k] ? e0_q[k] : '0;
`else
      head[k] = e0_q[k];
`endif
    end
  end

  assign f0 = head[0];
  assign f1 = head[1];
  assign f2 = head[2];
  assign f3 = head[3];

endmodule

// File: tb/tb_cjb_nbit_demux1to4_buf_v.sv
module tb_cjb_nbit_demux1to4_buf_v;

  logic       clock;
  logic       resetn;
  logic [7:0] d;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] f3, f2, f1, f0;
  logic [3:0] out_valid;
  logic [3:0] out_ready;

  int checks = 0;
  int errors = 0;

  cjb_nbit_demux1to4_buf_v #(.n(8)) dut (
    .clock(clock),
    .resetn(resetn),
    .d(d),
    .s(s),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .f3(f3),
    .f2(f2),
    .f1(f1),
    .f0(f0),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_f(input int k);
    case (k)
      0: return f0;
      1: return f1;
      2: return f2;
      default: return f3;
    endcase
  endfunction

  // Behavioural model: one queue per channel, capacity 2; last popped word
  // per channel stands in for what an idle output shows.
  logic [7:0] mq [4][$];
  logic [7:0] stale [4];

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        stale[k] = 8'h00;
      end
    end else begin
      bit acc;
      acc = in_valid && (mq[s].size() < 2);
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() > 0 && out_ready[k]) begin
          stale[k] = mq[k][0];
          void'(mq[k].pop_front());
        end
      end
      if (acc) mq[s].push_back(d);
    end
  end

  function automatic logic [7:0] model_f(input int k);
    if (mq[k].size() > 0) return mq[k][0];
`ifdef CJB_DEMUX_ZERO_IDLE_EN
    return 8'h00;
`else
    return stale[k];
`endif
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, (mq[s].size() < 2)});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("cmp_out_valid%0d", k), {31'd0, out_valid[k]}, {31'd0, (mq[k].size() != 0)});
        chk($sformatf("cmp_f%0d", k), {24'd0, dut_f(k)}, {24'd0, model_f(k)});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, {28'd0, out_valid}, 32'h0);
    chk({tag, "_f"}, {f3, f2, f1, f0}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      #1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'h1);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    d         = '0;
    s         = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    #1;
    check_reset_state("reset");
    cyc();
    resetn = 1'b1;

    // Steering
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      s        = 2'(k);
      d        = 8'hA0 + 8'(k);
      cyc();
      chk("steer_valid", {28'd0, out_valid}, 32'h1 << k);
      chk("steer_data", {24'd0, dut_f(k)}, 32'hA0 + k);
    end
    in_valid = 1'b0;
    cyc();
    chk("steer_drain", {28'd0, out_valid}, 32'h0);

    // Backpressure on channel 2
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    s         = 2'd2;
    d         = 8'h11;
    cyc();
    chk("bp_f2_first", {24'd0, f2}, 32'h11);
    chk("bp_ready_one", {31'd0, in_ready}, 32'h1);
    d = 8'h22;
    cyc();
    d = 8'h33;
    #1;
    chk("bp_ready_full", {31'd0, in_ready}, 32'h0);
    cyc();
    chk("bp_ready_held", {31'd0, in_ready}, 32'h0);
    chk("bp_f2_held", {24'd0, f2}, 32'h11);
    out_ready = 4'hF;
    #1;
    chk("bp_ready_full_pop", {31'd0, in_ready}, 32'h0);
    cyc();
    chk("bp_f2_second", {24'd0, f2}, 32'h22);
    chk("bp_ready_freed", {31'd0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
    chk("bp_f2_third", {24'd0, f2}, 32'h33);
    cyc();
    chk("bp_empty", {28'd0, out_valid}, 32'h0);

    // Simultaneous push and pop on a ONE channel
    out_ready = 4'h0;
    in_valid  = 1'b1;
    s         = 2'd1;
    d         = 8'h55;
    cyc();
    chk("sim_f1_55", {24'd0, f1}, 32'h55);
    d         = 8'h66;
    out_ready = 4'b0010;
    cyc();
    in_valid = 1'b0;
    chk("sim_f1_66", {24'd0, f1}, 32'h66);
    chk("sim_valid", {28'd0, out_valid}, 32'h2);
    chk("sim_ready_one", {31'd0, in_ready}, 32'h1);
    out_ready = 4'hF;
    cyc();

    // Independence: channel 3 full, channel 0 still accepts
    out_ready = 4'h0;
    in_valid  = 1'b1;
    s         = 2'd3;
    d         = 8'h77;
    cyc();
    d = 8'h78;
    cyc();
    chk("ind_ch3_full", {31'd0, in_ready}, 32'h0);
    s = 2'd0;
    d = 8'h7E;
    #1;
    chk("ind_ch0_ready", {31'd0, in_ready}, 32'h1);
    cyc();
    in_valid = 1'b0;
    chk("ind_f0", {24'd0, f0}, 32'h7E);
    chk("ind_f3", {24'd0, f3}, 32'h77);
    chk("ind_valid", {28'd0, out_valid}, 32'h9);
    out_ready = 4'hF;
    cyc();
    chk("ind_f3_next", {24'd0, f3}, 32'h78);
    cyc();

    // Sustained throughput into channel 1
    in_valid = 1'b1;
    s        = 2'd1;
    for (int i = 0; i < 8; i++) begin
      d = 8'(8'h40 + i);
      cyc();
      chk("tput_f1", {24'd0, f1}, 32'h40 + i);
      chk("tput_valid", {28'd0, out_valid}, 32'h2);
    end
    in_valid = 1'b0;
    cyc();

    // Idle output after drain
    out_ready = 4'h0;
    in_valid  = 1'b1;
    s         = 2'd0;
    d         = 8'hC3;
    cyc();
    in_valid  = 1'b0;
    out_ready = 4'h1;
    cyc();
    chk("idle_valid", {31'd0, out_valid[0]}, 32'h0);
`ifdef CJB_DEMUX_ZERO_IDLE_EN
    chk("idle_f0", {24'd0, f0}, 32'h00);
`else
    chk("idle_f0", {24'd0, f0}, 32'hC3);
`endif

    // Reset mid-operation
    out_ready = 4'h0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      d = 8'(8'h90 + k);
      cyc();
    end
    chk("pre_rst_valid", {28'd0, out_valid}, 32'hF);
    #2;
    resetn = 1'b0;
    #1;
    in_valid = 1'b0;
    check_reset_state("midrst");
    cyc();
    resetn = 1'b1;
    cyc();
    chk("post_rst_valid", {28'd0, out_valid}, 32'h0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout: got still running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
